// File: rtl/dataset_feeder.sv
// Training-set store feeding cnn_top: one registered image plus its one-hot labels at a time.
// Images are fetched word by word from on-chip memory and advance on each softmax_done pulse.
module dataset_feeder #(
    parameter int WIDTH            = 48,
    parameter int INPUT_DIM_HEIGHT = 10,
    parameter int INPUT_DIM_WIDTH  = 10,
    parameter int INPUT_SIZE       = INPUT_DIM_HEIGHT * INPUT_DIM_WIDTH,
    parameter int FCL_OUTPUT_DIM   = 10,
    parameter int NUM_IMAGES       = 1000,
    parameter int NUM_EPOCHS       = 5,
    localparam int IMG_DEPTH       = NUM_IMAGES * INPUT_SIZE,
    localparam int LBL_DEPTH       = NUM_IMAGES * FCL_OUTPUT_DIM,
    localparam int IMG_AW          = $clog2(IMG_DEPTH),
    localparam int LBL_AW          = $clog2(LBL_DEPTH),
    localparam int IDX_W           = $clog2(NUM_IMAGES),
    localparam int EP_W            = $clog2(NUM_EPOCHS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    img_wr_en,
    input  logic [IMG_AW-1:0]       img_wr_addr,
    input  logic signed [WIDTH-1:0] img_wr_data,
    input  logic                    lbl_wr_en,
    input  logic [LBL_AW-1:0]       lbl_wr_addr,
    input  logic signed [WIDTH-1:0] lbl_wr_data,
    input  logic                    softmax_done,
    output logic signed [WIDTH-1:0] input_data [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
    output logic signed [WIDTH-1:0] input_labels [FCL_OUTPUT_DIM],
    output logic [IDX_W-1:0]        input_index,
    output logic                    data_valid,
    output logic [EP_W-1:0]         epoch,
    output logic                    busy,
    output logic                    finished,
    output logic                    wr_err
);

    localparam int KW = $clog2(INPUT_SIZE + 1);
    localparam int DW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int LW = (FCL_OUTPUT_DIM > 1) ? $clog2(FCL_OUTPUT_DIM) : 1;
    localparam logic [KW-1:0]    K_END    = KW'(INPUT_SIZE);
    localparam logic [KW-1:0]    K_LBL    = KW'(FCL_OUTPUT_DIM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IMAGES - 1);
    localparam logic [EP_W-1:0]  EP_END   = EP_W'(NUM_EPOCHS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [EP_W-1:0]   epoch_q, epoch_d;
    logic [KW-1:0]     k_q, k_d;
    logic              valid_q, valid_d;
    logic              wr_err_q, wr_err_d;

    logic signed [WIDTH-1:0] img_mem [IMG_DEPTH];
    logic signed [WIDTH-1:0] lbl_mem [LBL_DEPTH];
    logic signed [WIDTH-1:0] rd_img_q, rd_lbl_q;
    logic signed [WIDTH-1:0] data_q [INPUT_SIZE];
    logic signed [WIDTH-1:0] lbl_q  [FCL_OUTPUT_DIM];

    logic              cap_img_q, cap_lbl_q;
    logic [DW-1:0]     cap_pos_q;

    logic              wr_ok, busy_w;
    logic              img_wr_hit, lbl_wr_hit;
    logic              issue_img, issue_lbl;
    logic [IMG_AW-1:0] rd_img_addr;
    logic [LBL_AW-1:0] rd_lbl_addr;

    assign busy_w     = (state_q == S_FETCH) || (state_q == S_PRESENT);
    assign wr_ok      = (state_q == S_IDLE) || (state_q == S_DONE);
    assign img_wr_hit = img_wr_en && wr_ok && (32'(img_wr_addr) < IMG_DEPTH);
    assign lbl_wr_hit = lbl_wr_en && wr_ok && (32'(lbl_wr_addr) < LBL_DEPTH);

    // k == INPUT_SIZE is the drain cycle: no read issued, last word still landing.
    assign issue_img   = (state_q == S_FETCH) && (k_q != K_END);
    assign issue_lbl   = issue_img && (k_q < K_LBL);
    assign rd_img_addr = IMG_AW'(idx_q) * IMG_AW'(INPUT_SIZE) + IMG_AW'(k_q);
    assign rd_lbl_addr = LBL_AW'(idx_q) * LBL_AW'(FCL_OUTPUT_DIM) + LBL_AW'(k_q);

    always_ff @(posedge clk) begin
        if (img_wr_hit) img_mem[img_wr_addr] <= img_wr_data;
        if (lbl_wr_hit) lbl_mem[lbl_wr_addr] <= lbl_wr_data;
        if (issue_img)  rd_img_q <= img_mem[rd_img_addr];
        if (issue_lbl)  rd_lbl_q <= lbl_mem[rd_lbl_addr];
    end

    // Read data lands one cycle after issue; the capture tags travel with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_img_q <= 1'b0;
            cap_lbl_q <= 1'b0;
            cap_pos_q <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) data_q[i] <= '0;
            for (int j = 0; j < FCL_OUTPUT_DIM; j++) lbl_q[j] <= '0;
        end else begin
            cap_img_q <= issue_img;
            cap_lbl_q <= issue_lbl;
            cap_pos_q <= DW'(k_q);
            if (cap_img_q) data_q[cap_pos_q] <= rd_img_q;
            if (cap_lbl_q) lbl_q[LW'(cap_pos_q)] <= rd_lbl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            epoch_q  <= '0;
            k_q      <= '0;
            valid_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            epoch_q  <= epoch_d;
            k_q      <= k_d;
            valid_q  <= valid_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        epoch_d  = epoch_q;
        k_d      = k_q;
        valid_d  = valid_q;
        wr_err_d = (img_wr_en || lbl_wr_en) && busy_w;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    epoch_d = '0;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                if (k_q == K_END) begin
                    state_d = S_PRESENT;
                    valid_d = 1'b1;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_PRESENT: begin
                if (softmax_done) begin
                    valid_d = 1'b0;
                    k_d     = '0;
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        idx_d   = '0;
                        epoch_d = epoch_q + EP_W'(1);
                        state_d = (epoch_q + EP_W'(1) == EP_END) ? S_DONE : S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar r = 0; r < INPUT_DIM_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < INPUT_DIM_WIDTH; c++) begin : g_col
            assign input_data[r][c] = data_q[r * INPUT_DIM_WIDTH + c];
        end
    end
    for (genvar j = 0; j < FCL_OUTPUT_DIM; j++) begin : g_lbl
        assign input_labels[j] = lbl_q[j];
    end

    assign input_index = idx_q;
    assign data_valid  = valid_q;
    assign epoch       = epoch_q;
    assign busy        = busy_w;
    assign finished    = (state_q == S_DONE);
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_dataset_feeder.sv
// Bench for dataset_feeder: small 4x4/3-image instance checked against a behavioural model
// every cycle, plus a default-size instance checked with literal expectations.
module tb_dataset_feeder;

    localparam int HT = 4, WD = 4, IS = 16, FC = 4, NI = 3, NE = 2;
    localparam int P_IDLE = 0, P_FETCH = 1, P_PRESENT = 2, P_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, start, img_wr_en, lbl_wr_en, softmax_done;
    logic [5:0]         img_wr_addr;
    logic [3:0]         lbl_wr_addr;
    logic signed [47:0] img_wr_data, lbl_wr_data;
    logic signed [47:0] input_data [HT][WD];
    logic signed [47:0] input_labels [FC];
    logic [1:0]         input_index, epoch;
    logic               data_valid, busy, finished, wr_err;

    logic               start2, img2_en, lbl2_en, sd2;
    logic [7:0]         img2_addr;
    logic [4:0]         lbl2_addr;
    logic signed [47:0] img2_data, lbl2_data;
    logic signed [47:0] d2_data [10][10];
    logic signed [47:0] d2_lbl [10];
    logic [0:0]         d2_idx;
    logic [2:0]         d2_ep;
    logic               d2_valid, d2_busy, d2_fin, d2_err;

    dataset_feeder #(.WIDTH(48), .INPUT_DIM_HEIGHT(HT), .INPUT_DIM_WIDTH(WD),
                     .FCL_OUTPUT_DIM(FC), .NUM_IMAGES(NI), .NUM_EPOCHS(NE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
        .lbl_wr_en(lbl_wr_en), .lbl_wr_addr(lbl_wr_addr), .lbl_wr_data(lbl_wr_data),
        .softmax_done(softmax_done), .input_data(input_data), .input_labels(input_labels),
        .input_index(input_index), .data_valid(data_valid), .epoch(epoch),
        .busy(busy), .finished(finished), .wr_err(wr_err));

    dataset_feeder #(.NUM_IMAGES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .img_wr_en(img2_en), .img_wr_addr(img2_addr), .img_wr_data(img2_data),
        .lbl_wr_en(lbl2_en), .lbl_wr_addr(lbl2_addr), .lbl_wr_data(lbl2_data),
        .softmax_done(sd2), .input_data(d2_data), .input_labels(d2_lbl),
        .input_index(d2_idx), .data_valid(d2_valid), .epoch(d2_ep),
        .busy(d2_busy), .finished(d2_fin), .wr_err(d2_err));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, cycles since fetch entry, stored set contents.
    int     m_phase = P_IDLE, m_cnt = 0, m_idx = 0, m_ep = 0, m_img = 0;
    bit     m_valid = 0, m_err = 0, m_have = 0;
    longint img_m [NI*IS];
    longint lbl_m [NI*FC];

    always @(posedge clk) begin
        if (reset) begin
            m_phase = P_IDLE; m_cnt = 0; m_idx = 0; m_ep = 0;
            m_valid = 0; m_err = 0; m_have = 0;
        end else begin
            m_err = (img_wr_en || lbl_wr_en) && (m_phase == P_FETCH || m_phase == P_PRESENT);
            if (m_phase == P_IDLE || m_phase == P_DONE) begin
                if (img_wr_en && int'(img_wr_addr) < NI*IS) img_m[int'(img_wr_addr)] = img_wr_data;
                if (lbl_wr_en && int'(lbl_wr_addr) < NI*FC) lbl_m[int'(lbl_wr_addr)] = lbl_wr_data;
            end
            case (m_phase)
                P_IDLE, P_DONE:
                    if (start) begin
                        m_phase = P_FETCH; m_cnt = 0; m_idx = 0; m_ep = 0;
                    end
                P_FETCH: begin
                    m_cnt++;
                    if (m_cnt == IS + 1) begin
                        m_phase = P_PRESENT; m_valid = 1; m_img = m_idx; m_have = 1;
                    end
                end
                default:
                    if (softmax_done) begin
                        m_valid = 0; m_cnt = 0;
                        if (m_idx < NI - 1) begin
                            m_idx++; m_phase = P_FETCH;
                        end else begin
                            m_idx = 0; m_ep++;
                            m_phase = (m_ep == NE) ? P_DONE : P_FETCH;
                        end
                    end
            endcase
        end
        #1;
        chk("busy", busy, (m_phase == P_FETCH || m_phase == P_PRESENT));
        chk("finished", finished, (m_phase == P_DONE));
        chk("epoch", epoch, m_ep);
        chk("input_index", input_index, m_idx);
        chk("data_valid", data_valid, m_valid);
        chk("wr_err", wr_err, m_err);
        if ((m_phase == P_PRESENT || m_phase == P_DONE) && m_have) begin
            for (int r = 0; r < HT; r++)
                for (int c = 0; c < WD; c++)
                    chk("input_data", input_data[r][c], img_m[m_img*IS + r*WD + c]);
            for (int j = 0; j < FC; j++)
                chk("input_labels", input_labels[j], lbl_m[m_img*FC + j]);
        end else if (m_phase == P_IDLE && !m_have) begin
            for (int r = 0; r < HT; r++)
                for (int c = 0; c < WD; c++)
                    chk("input_data_zero", input_data[r][c], 0);
            for (int j = 0; j < FC; j++)
                chk("input_labels_zero", input_labels[j], 0);
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0; cyc = 0;
    endtask

    task automatic do_done(input bit with_start);
        softmax_done = 1'b1; start = with_start; step();
        softmax_done = 1'b0; start = 1'b0; cyc = 0;
    endtask

    // kind 1: softmax_done pulse, kind 2: image write to address 0 (both mid-fetch).
    task automatic wait_valid(input int inject_at, input int kind, output int errs);
        errs = 0;
        while (!data_valid && cyc < 400) begin
            if (cyc == inject_at && kind == 1) softmax_done = 1'b1;
            if (cyc == inject_at && kind == 2) begin
                img_wr_en = 1'b1; img_wr_addr = 6'd0; img_wr_data = 48'sd7;
            end
            step();
            softmax_done = 1'b0; img_wr_en = 1'b0;
            if (wr_err) errs++;
        end
    endtask

    int errs;

    initial begin
        reset = 1'b1; start = 1'b0; softmax_done = 1'b0;
        img_wr_en = 1'b0; lbl_wr_en = 1'b0; img_wr_addr = '0; lbl_wr_addr = '0;
        img_wr_data = '0; lbl_wr_data = '0;
        start2 = 1'b0; img2_en = 1'b0; lbl2_en = 1'b0; sd2 = 1'b0;
        img2_addr = '0; lbl2_addr = '0; img2_data = '0; lbl2_data = '0;
        repeat (3) step();
        reset = 1'b0;

        for (int a = 0; a < NI*IS; a++) begin
            img_wr_en = 1'b1; img_wr_addr = 6'(a); img_wr_data = 48'(a + 100); step();
        end
        img_wr_addr = 6'd50; img_wr_data = 48'sd999; step();
        img_wr_en = 1'b0;
        for (int b = 0; b < NI*FC; b++) begin
            lbl_wr_en = 1'b1; lbl_wr_addr = 4'(b); lbl_wr_data = 48'(-(b + 1)); step();
        end
        lbl_wr_addr = 4'd13; lbl_wr_data = 48'sd555; step();
        lbl_wr_en = 1'b0;
        step();

        do_start();
        wait_valid(-1, 0, errs);
        chk("latency_img0", cyc, 17);
        chk("img0_d00", input_data[0][0], 100);
        chk("img0_d33", input_data[3][3], 115);
        chk("img0_l0", input_labels[0], -1);
        chk("img0_l3", input_labels[3], -4);
        chk("img0_index", input_index, 0);

        start = 1'b1; step(); start = 1'b0; step();
        chk("start_in_present_index", input_index, 0);
        chk("start_in_present_valid", data_valid, 1);

        do_done(1'b0);
        wait_valid(3, 1, errs);
        chk("latency_img1_sd_in_fetch", cyc, 17);
        chk("img1_index", input_index, 1);
        chk("img1_epoch", epoch, 0);
        chk("img1_d00", input_data[0][0], 116);

        do_done(1'b1);
        wait_valid(4, 2, errs);
        chk("latency_img2", cyc, 17);
        chk("wr_err_pulses", errs, 1);
        chk("img2_index", input_index, 2);
        chk("img2_d00", input_data[0][0], 132);

        do_done(1'b0);
        wait_valid(-1, 0, errs);
        chk("wrap_index", input_index, 0);
        chk("wrap_epoch", epoch, 1);
        chk("wrap_d00_after_dropped_write", input_data[0][0], 100);

        do_done(1'b0); wait_valid(-1, 0, errs);
        do_done(1'b0); wait_valid(-1, 0, errs);
        chk("ep1_img2_index", input_index, 2);
        do_done(1'b0);
        repeat (3) step();
        chk("done_finished", finished, 1);
        chk("done_busy", busy, 0);
        chk("done_epoch", epoch, 2);
        chk("done_valid", data_valid, 0);
        chk("done_held_d00", input_data[0][0], 132);

        do_start();
        chk("rerun_finished_clear", finished, 0);
        wait_valid(-1, 0, errs);
        chk("rerun_latency", cyc, 17);
        chk("rerun_d00", input_data[0][0], 100);
        chk("rerun_epoch", epoch, 0);

        do_done(1'b0);
        repeat (5) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_index", input_index, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_d00", input_data[0][0], 0);
        chk("rst_l0", input_labels[0], 0);
        repeat (3) step();
        chk("rst_stays_idle", busy, 0);
        do_start();
        wait_valid(-1, 0, errs);
        chk("post_rst_latency", cyc, 17);
        chk("post_rst_d00", input_data[0][0], 100);
        chk("post_rst_d33", input_data[3][3], 115);
        chk("post_rst_index", input_index, 0);

        for (int a = 0; a < 100; a++) begin
            img2_en = 1'b1; img2_addr = 8'(a); img2_data = 48'(a); step();
        end
        img2_en = 1'b0;
        for (int b = 0; b < 10; b++) begin
            lbl2_en = 1'b1; lbl2_addr = 5'(b); lbl2_data = 48'(1000 + b); step();
        end
        lbl2_en = 1'b0;
        start2 = 1'b1; step(); start2 = 1'b0; cyc = 0;
        while (!d2_valid && cyc < 400) step();
        chk("dflt_latency", cyc, 101);
        chk("dflt_d99", d2_data[9][9], 99);
        chk("dflt_d00", d2_data[0][0], 0);
        chk("dflt_d47", d2_data[4][7], 47);
        chk("dflt_l9", d2_lbl[9], 1009);
        chk("dflt_index", d2_idx, 0);
        chk("dflt_busy", d2_busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dataset_feeder.md
Name: dataset_feeder

Overview:
- Owns the on-chip training set and presents one image plus its one-hot label vector at a time to cnn_top.
- Sits directly upstream of cnn_top and replaces ad-hoc combinational memory indexing with a sequenced, registered fetch.
- Advances to the next image on each softmax_done pulse from cnn_top, wraps around the image set and counts epochs, then stops after NUM_EPOCHS.

Parameters:
- WIDTH, 48, signed data word width for pixels and labels.
- INPUT_DIM_HEIGHT, 10, image rows.
- INPUT_DIM_WIDTH, 10, image columns.
- INPUT_SIZE, INPUT_DIM_HEIGHT*INPUT_DIM_WIDTH, words per image; must be >= FCL_OUTPUT_DIM.
- FCL_OUTPUT_DIM, 10, label words per image.
- NUM_IMAGES, 1000, images stored.
- NUM_EPOCHS, 5, passes over the set before finishing; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run from image 0, epoch 0.
- img_wr_en  in  1  image memory write strobe.
- img_wr_addr  in  $clog2(NUM_IMAGES*INPUT_SIZE)  image memory word address.
- img_wr_data  in  WIDTH  signed pixel word.
- lbl_wr_en  in  1  label memory write strobe.
- lbl_wr_addr  in  $clog2(NUM_IMAGES*FCL_OUTPUT_DIM)  label memory word address.
- lbl_wr_data  in  WIDTH  signed label word.
- softmax_done  in  1  pulse from cnn_top; the current image is consumed.
- input_data  out  WIDTH x [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH]  registered image.
- input_labels  out  WIDTH x [FCL_OUTPUT_DIM]  registered labels.
- input_index  out  $clog2(NUM_IMAGES)  index of the image being fetched or presented.
- data_valid  out  1  high while input_data and input_labels hold a complete image.
- epoch  out  $clog2(NUM_EPOCHS+1)  completed epochs.
- busy  out  1  high in FETCH or PRESENT.
- finished  out  1  high in DONE.
- wr_err  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset values: all outputs 0, including input_data, input_labels, input_index, data_valid, epoch, busy, finished and wr_err. State goes to IDLE.
- Reset does not clear either memory. Reset asserted mid-FETCH or mid-PRESENT aborts the run immediately.
- Memories: synchronous write, synchronous read with 1-cycle read latency.
- Writes are accepted only in IDLE or DONE. A write in FETCH or PRESENT is dropped and pulses wr_err the next cycle; img_wr_en and lbl_wr_en together give one pulse.
- IDLE:
  - start -> FETCH; input_index=0, epoch=0, fetch counter k=0.
- FETCH:
  - Cycle k (0..INPUT_SIZE-1) reads image word input_index*INPUT_SIZE+k.
  - Cycles 0..FCL_OUTPUT_DIM-1 also read label word input_index*FCL_OUTPUT_DIM+k.
  - Read data lands one cycle later, in row-major order: input_data[k/INPUT_DIM_WIDTH][k%INPUT_DIM_WIDTH].
  - After the last word lands -> PRESENT; data_valid rises. With defaults, data_valid is high exactly INPUT_SIZE+1 = 101 cycles after FETCH entry.
  - data_valid is 0 throughout FETCH. Partially overwritten registers are not valid.
- PRESENT:
  - Outputs are held stable until softmax_done.
  - On softmax_done: data_valid drops next cycle. If input_index < NUM_IMAGES-1, input_index increments -> FETCH.
  - Otherwise input_index=0 and epoch increments. If the new epoch == NUM_EPOCHS -> DONE, else -> FETCH.
- DONE:
  - finished=1; input_data, input_labels and input_index are held.
  - start -> FETCH with input_index=0 and epoch=0; finished clears.
- Ignored events:
  - softmax_done outside PRESENT.
  - start outside IDLE or DONE.
  - start and softmax_done in the same cycle in PRESENT: softmax_done wins.
- busy = (state==FETCH || state==PRESENT).
- No arithmetic on data; words are copied bit-exact.
- Address products use full-width unsigned math. Out-of-range write addresses are dropped silently.

Test Plan (INPUT_DIM 4x4, FCL_OUTPUT_DIM=4, NUM_IMAGES=3, NUM_EPOCHS=2 unless noted):
- Load pixel word a = a+100 and label word b = -(b+1); pulse start -> data_valid rises 17 cycles later; input_data[0][0]=100, input_data[3][3]=115, input_labels = {-1,-2,-3,-4}, input_index=0.
- softmax_done in PRESENT, three times -> input_index 1, 2, then 0 with epoch=1. Image 2 shows input_data[0][0]=132. After the sixth done: finished=1, busy=0, epoch=2.
- img_wr_en during FETCH to address 0 with data 7 -> wr_err pulses once. A rerun from DONE still reads input_data[0][0]=100.
- softmax_done during FETCH, and start during PRESENT -> no effect; index, epoch and the valid timing are unchanged.
- reset asserted mid-FETCH of image 1 -> next cycle all outputs are 0 and state is IDLE; start then re-presents image 0 with its original data.
- Default parameters, NUM_IMAGES=2, one image loaded with values 0..99 -> data_valid is high 101 cycles after start; input_data[9][9]=99.
